mult_div_unit: RTL and testbench

//   Iterative HI/LO multiply/divide unit for MULT, MULTU, DIV, DIVU, MTHI and MTLO.

---
 rtl/mult_div_unit.sv | 161 ++++++++++++++++
 tb/tb_mult_div_unit.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/mult_div_unit.sv
// rtl/mult_div_unit.sv - iterative HI/LO multiply/divide unit (MULT, MULTU, DIV, DIVU, MTHI, MTLO)
//
// Radix-2 shift-add multiplier and restoring divider sharing one 2*WIDTH accumulator.
// An operation takes WIDTH+1 cycles from the start edge to the done pulse.
//
// Ports:
//   clk, rst           clock, asynchronous active-high reset
//   start, op          request an operation (00 MULT, 01 MULTU, 10 DIV, 11 DIVU), sampled when idle
//   operand_a/b        rs / rt values (multiplicand/dividend, multiplier/divisor)
//   mthi, mtlo, wdata  direct writes of hi/lo, accepted only when idle
//   hi, lo             HI/LO registers
//   busy               operation in progress
//   done               one-cycle pulse when a new result lands in hi/lo
//   div_by_zero        pulses with done when a divide had a zero divisor
module mult_div_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] operand_a,
  input  logic [WIDTH-1:0] operand_b,
  input  logic             mthi,
  input  logic             mtlo,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             busy,
  output logic             done,
  output logic             div_by_zero
);

  localparam int CW = $clog2(WIDTH);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_CALC  = 2'd1;
  localparam logic [1:0] S_FIXUP = 2'd2;

  logic [1:0]         state;
  logic [CW-1:0]      count;
  logic               op_div;
  logic               sign_a;
  logic               sign_b;
  logic [WIDTH-1:0]   opnd;     // multiplicand (mult) or divisor (div), absolute value
  logic [WIDTH-1:0]   a_raw;    // dividend as presented, returned in hi on divide by zero
  logic [2*WIDTH-1:0] acc;      // mult: {partial product, multiplier}; div: {remainder, quotient}
  logic [WIDTH-1:0]   hi_r;
  logic [WIDTH-1:0]   lo_r;
  logic               done_r;
  logic               dbz_r;

  // Signed ops are the even opcodes; magnitudes wrap modulo 2^WIDTH, so -2^(W-1) stays 0x80..0.
  logic             start_signed;
  logic [WIDTH-1:0] a_abs;
  logic [WIDTH-1:0] b_abs;

  assign start_signed = ~op[0];
  assign a_abs = (start_signed && operand_a[WIDTH-1]) ? -operand_a : operand_a;
  assign b_abs = (start_signed && operand_b[WIDTH-1]) ? -operand_b : operand_b;

  // One iteration of the selected algorithm.
  logic [WIDTH:0]     mul_sum;
  logic [WIDTH:0]     rem_sh;
  logic [WIDTH:0]     rem_diff;
  logic [2*WIDTH-1:0] acc_step;

  always_comb begin
    mul_sum  = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, opnd} : '0);
    rem_sh   = {acc[2*WIDTH-1:WIDTH], acc[WIDTH-1]};
    rem_diff = rem_sh - {1'b0, opnd};
    acc_step = acc;
    if (!op_div) begin
      acc_step = {mul_sum, acc[WIDTH-1:1]};
    end else if (!rem_diff[WIDTH]) begin
      // No borrow: shifted remainder was >= divisor.
      acc_step = {rem_diff[WIDTH-1:0], acc[WIDTH-2:0], 1'b1};
    end else begin
      acc_step = {rem_sh[WIDTH-1:0], acc[WIDTH-2:0], 1'b0};
    end
  end

  // Sign correction and divide-by-zero substitution applied on the completion edge.
  logic [2*WIDTH-1:0] prod_fix;
  logic [WIDTH-1:0]   res_hi;
  logic [WIDTH-1:0]   res_lo;
  logic               res_dbz;

  always_comb begin
    prod_fix = (sign_a ^ sign_b) ? -acc : acc;
    res_hi   = prod_fix[2*WIDTH-1:WIDTH];
    res_lo   = prod_fix[WIDTH-1:0];
    res_dbz  = 1'b0;
    if (op_div) begin
      if (opnd == '0) begin
        res_hi  = a_raw;
        res_lo  = '1;
        res_dbz = 1'b1;
      end else begin
        res_lo = (sign_a ^ sign_b) ? -acc[WIDTH-1:0] : acc[WIDTH-1:0];
        res_hi = sign_a ? -acc[2*WIDTH-1:WIDTH] : acc[2*WIDTH-1:WIDTH];
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= S_IDLE;
      count  <= '0;
      op_div <= 1'b0;
      sign_a <= 1'b0;
      sign_b <= 1'b0;
      opnd   <= '0;
      a_raw  <= '0;
      acc    <= '0;
      hi_r   <= '0;
      lo_r   <= '0;
      done_r <= 1'b0;
      dbz_r  <= 1'b0;
    end else begin
      done_r <= 1'b0;
      dbz_r  <= 1'b0;
      case (state)
        S_IDLE: begin
          if (mthi) hi_r <= wdata;
          if (mtlo) lo_r <= wdata;
          if (start) begin
            state  <= S_CALC;
            count  <= '0;
            op_div <= op[1];
            sign_a <= start_signed & operand_a[WIDTH-1];
            sign_b <= start_signed & operand_b[WIDTH-1];
            a_raw  <= operand_a;
            opnd   <= op[1] ? b_abs : a_abs;
            acc    <= {{WIDTH{1'b0}}, (op[1] ? a_abs : b_abs)};
          end
        end
        S_CALC: begin
          acc   <= acc_step;
          count <= count + 1'b1;
          if (count == CW'(WIDTH - 1)) state <= S_FIXUP;
        end
        S_FIXUP: begin
          hi_r   <= res_hi;
          lo_r   <= res_lo;
          dbz_r  <= res_dbz;
          done_r <= 1'b1;
          state  <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign hi          = hi_r;
  assign lo          = lo_r;
  assign busy        = (state != S_IDLE);
  assign done        = done_r;
  assign div_by_zero = dbz_r;

endmodule

// File: tb/tb_mult_div_unit.sv
// tb/tb_mult_div_unit.sv - randomized self-checking bench for mult_div_unit
module tb_mult_div_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [1:0]  op;
  logic [31:0] operand_a;
  logic [31:0] operand_b;
  logic        mthi;
  logic        mtlo;
  logic [31:0] wdata;
  logic [31:0] hi;
  logic [31:0] lo;
  logic        busy;
  logic        done;
  logic        div_by_zero;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  mult_div_unit #(.WIDTH(32)) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .op         (op),
    .operand_a  (operand_a),
    .operand_b  (operand_b),
    .mthi       (mthi),
    .mtlo       (mtlo),
    .wdata      (wdata),
    .hi         (hi),
    .lo         (lo),
    .busy       (busy),
    .done       (done),
    .div_by_zero(div_by_zero)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Architectural result computed with plain 64-bit arithmetic.
  task automatic model(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                       output logic [31:0] eh, output logic [31:0] el, output logic edz);
    longint      sa;
    longint      sb;
    longint      q;
    longint      r;
    logic [63:0] p;
    sa  = $signed(a);
    sb  = $signed(b);
    edz = 1'b0;
    eh  = '0;
    el  = '0;
    case (o)
      2'b00: begin p = sa * sb; eh = p[63:32]; el = p[31:0]; end
      2'b01: begin p = {32'h0, a} * {32'h0, b}; eh = p[63:32]; el = p[31:0]; end
      default: begin
        if (b == 32'h0) begin
          eh = a; el = 32'hFFFF_FFFF; edz = 1'b1;
        end else if (o == 2'b10) begin
          q = sa / sb; r = sa % sb;
          el = q[31:0]; eh = r[31:0];
        end else begin
          el = a / b; eh = a % b;
        end
      end
    endcase
  endtask

  task automatic run_op(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                        input bit interfere, input bit with_mt);
    logic [31:0] eh;
    logic [31:0] el;
    logic        edz;
    logic [31:0] w;
    int          n;
    bit          busy_ok;
    model(o, a, b, eh, el, edz);
    @(negedge clk);
    start = 1'b1; op = o; operand_a = a; operand_b = b;
    w = $urandom;
    if (with_mt) begin mtlo = 1'b1; wdata = w; end
    @(posedge clk); #1;
    start = 1'b0; mtlo = 1'b0;
    operand_a = $urandom; operand_b = $urandom; op = 2'($urandom);
    if (with_mt) check("mtlo_with_start", lo, w);
    n = 0;
    busy_ok = 1'b1;
    while (!done && n < 60) begin
      if (!busy) busy_ok = 1'b0;
      if (interfere && n == 4) begin
        start = 1'b1; mthi = 1'b1; mtlo = 1'b1; wdata = $urandom;
      end
      if (interfere && n == 5) begin
        start = 1'b0; mthi = 1'b0; mtlo = 1'b0;
      end
      @(posedge clk); #1;
      n++;
    end
    check("latency", 64'(n), 64'd33);
    check("busy_during_op", 64'(busy_ok), 64'd1);
    check("busy_at_done", 64'(busy), 64'd0);
    check("hi", 64'(hi), 64'(eh));
    check("lo", 64'(lo), 64'(el));
    check("div_by_zero", 64'(div_by_zero), 64'(edz));
    @(posedge clk); #1;
    check("done_one_cycle", 64'(done), 64'd0);
    check("hi_hold", 64'(hi), 64'(eh));
  endtask

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 7))
      0:       return 32'h0;
      1:       return 32'h8000_0000;
      2:       return 32'hFFFF_FFFF;
      3:       return 32'h1;
      4:       return 32'($urandom_range(0, 300));
      default: return $urandom;
    endcase
  endfunction

  initial begin
    bit          saw_done;
    logic [31:0] keep_lo;
    rst = 1'b1; start = 1'b0; op = 2'b00; operand_a = '0; operand_b = '0;
    mthi = 1'b0; mtlo = 1'b0; wdata = '0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_hi", 64'(hi), 64'd0);
    check("rst_lo", 64'(lo), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_done", 64'(done), 64'd0);
    check("rst_dbz", 64'(div_by_zero), 64'd0);
    @(negedge clk); rst = 1'b0;

    run_op(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, 0);
    run_op(2'b00, 32'hFFFF_FFFD, 32'd7, 0, 0);
    run_op(2'b10, 32'hFFFF_FFF9, 32'd2, 0, 0);
    run_op(2'b11, 32'd100, 32'd7, 0, 0);
    run_op(2'b11, 32'd100, 32'd0, 0, 0);
    run_op(2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 0, 0);
    run_op(2'b10, 32'hFFFF_FFF9, 32'd0, 0, 0);
    run_op(2'b01, $urandom, $urandom, 1, 0);
    run_op(2'b10, $urandom, $urandom, 0, 1);

    // Idle register writes.
    keep_lo = lo;
    @(negedge clk); mthi = 1'b1; wdata = 32'h1234;
    @(posedge clk); #1;
    mthi = 1'b0;
    check("mthi_idle", 64'(hi), 64'h1234);
    check("mthi_lo_hold", 64'(lo), 64'(keep_lo));
    @(negedge clk); mthi = 1'b1; mtlo = 1'b1; wdata = 32'hCAFE_F00D;
    @(posedge clk); #1;
    mthi = 1'b0; mtlo = 1'b0;
    check("mthi_both", 64'(hi), 64'hCAFE_F00D);
    check("mtlo_both", 64'(lo), 64'hCAFE_F00D);

    // Asynchronous reset in the middle of a divide.
    @(negedge clk); start = 1'b1; op = 2'b10; operand_a = 32'd12345; operand_b = 32'd17;
    @(posedge clk); #1; start = 1'b0;
    repeat (9) @(posedge clk);
    #2 rst = 1'b1;
    #1;
    check("midrst_hi", 64'(hi), 64'd0);
    check("midrst_lo", 64'(lo), 64'd0);
    check("midrst_busy", 64'(busy), 64'd0);
    @(negedge clk); rst = 1'b0;
    saw_done = 1'b0;
    repeat (40) begin
      @(negedge clk);
      if (done) saw_done = 1'b1;
    end
    check("midrst_no_done", 64'(saw_done), 64'd0);
    run_op(2'b10, 32'd12345, 32'd17, 0, 0);

    for (int i = 0; i < 40; i++) begin
      run_op(2'($urandom), pick(), pick(), ($urandom_range(0, 3) == 0), ($urandom_range(0, 3) == 0));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
